// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv32_pkg                                                    |
// | Shared RV32I opcodes, bubble instruction and BHT counter encodings.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package rv32_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_branch_history_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : branch_history_table                                        |
// | 2-bit saturating counters, combinational lookup, synchronous update. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_history_table #(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc,
    output logic        rd_taken,
    input  logic        upd,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);
    import rv32_pkg::*;

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         ctr [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign rd_idx         = rd_pc[IDX_W+1:2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{rd_pc[31:IDX_W+2], rd_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Lookup returns the pre-update value when read and update hit the same entry.
    assign rd_taken = (ctr[rd_idx] >= WT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= WNT;
            end
        end else if (upd) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != ST) begin
                    ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
                end
            end else if (ctr[upd_idx] != SNT) begin
                ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : inst_fetch                                                  |
// | RV32I IF stage: PC register, static/BHT prediction, IF/ID latch.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] NOP_INSTR   = rv32_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        br_update,
    input  logic [31:0] br_update_pc,
    input  logic        br_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        predict_out
);
    import rv32_pkg::*;

    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_branch;
    logic        bht_taken;
    logic        predicted_taken;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign opcode    = imem_rdata[6:0];
    assign j_imm     = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                        imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign b_imm     = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                        imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign is_jal    = (opcode == OPC_JAL);
    assign is_branch = (opcode == OPC_BRANCH);

    branch_history_table #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (pc),
        .rd_taken  (bht_taken),
        .upd       (br_update),
        .upd_pc    (br_update_pc),
        .upd_taken (br_taken)
    );

    // JAL is always taken; JALR target is unknown here so it falls through to pc+4.
    assign predicted_taken = is_jal | (is_branch & bht_taken);

    always_comb begin
        next_pc = pc + 32'd4;
        if (is_jal) begin
            next_pc = pc + j_imm;
        end else if (predicted_taken) begin
            next_pc = pc + b_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc              <= RESET_PC;
            PC_out          <= 32'd0;
            instruction_out <= NOP_INSTR;
            predict_out     <= 1'b0;
        end else if (flush) begin
            pc              <= redirect_pc;
            PC_out          <= 32'd0;
            instruction_out <= NOP_INSTR;
            predict_out     <= 1'b0;
        end else if (!stall) begin
            pc              <= next_pc;
            PC_out          <= pc;
            instruction_out <= imem_rdata;
            predict_out     <= predicted_taken;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_inst_fetch                                               |
// | Directed vector table plus randomized run against a reference model. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL_16 = 32'h0100_00EF;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_update, br_taken, predict_out;
    logic [31:0] redirect_pc, br_update_pc, imem_addr, imem_rdata, PC_out, instruction_out;
    logic [31:0] rom [256];

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr[9:2]];

    inst_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .br_update       (br_update),
        .br_update_pc    (br_update_pc),
        .br_taken        (br_taken),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .predict_out     (predict_out)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_pcout, m_instr;
    logic        m_pred;
    int          m_ctr [16];

    typedef struct {
        bit          rst_n, stl, fls;
        logic [31:0] rdir;
        bit          upd;
        logic [31:0] upc;
        bit          tkn;
        logic [31:0] e_pc, e_pcout, e_instr;
        bit          e_pred;
    } vec_t;

    vec_t tbl [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] R(int a);
        return rom[a / 4];
    endfunction

    task automatic add(bit r, bit s, bit f, logic [31:0] rd, bit u, logic [31:0] up, bit t,
                       logic [31:0] epc, logic [31:0] epo, logic [31:0] ei, bit ep);
        vec_t v;
        v.rst_n = r; v.stl = s; v.fls = f; v.rdir = rd; v.upd = u; v.upc = up; v.tkn = t;
        v.e_pc = epc; v.e_pcout = epo; v.e_instr = ei; v.e_pred = ep;
        tbl.push_back(v);
    endtask

    task automatic drive(bit r, bit s, bit f, logic [31:0] rd, bit u, logic [31:0] up, bit t);
        reset = r; stall = s; flush = f; redirect_pc = rd;
        br_update = u; br_update_pc = up; br_taken = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int jimm(logic [31:0] r);
        return (r[31] ? -(1 << 20) : 0) + int'(r[19:12]) * 4096 + int'(r[20]) * 2048
               + int'(r[30:21]) * 2;
    endfunction

    function automatic int bimm(logic [31:0] r);
        return (r[31] ? -4096 : 0) + int'(r[7]) * 2048 + int'(r[30:25]) * 32
               + int'(r[11:8]) * 2;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] rd;
        logic [31:0] nxt;
        int          idx;
        int          u;
        bit          pred;
        if (!reset) begin
            m_pc = 32'd0; m_pcout = 32'd0; m_instr = NOP; m_pred = 1'b0;
            for (int i = 0; i < 16; i++) m_ctr[i] = 1;
            return;
        end
        rd   = rom[(m_pc / 4) % 256];
        idx  = int'((m_pc / 4) % 16);
        pred = (rd[6:0] == 7'h6F) || (rd[6:0] == 7'h63 && m_ctr[idx] >= 2);
        if (rd[6:0] == 7'h6F)  nxt = m_pc + 32'(jimm(rd));
        else if (pred)         nxt = m_pc + 32'(bimm(rd));
        else                   nxt = m_pc + 32'd4;
        if (flush) begin
            m_pc = redirect_pc; m_pcout = 32'd0; m_instr = NOP; m_pred = 1'b0;
        end else if (!stall) begin
            m_pcout = m_pc; m_instr = rd; m_pred = pred; m_pc = nxt;
        end
        if (br_update) begin
            u = int'((br_update_pc / 4) % 16);
            if (br_taken) m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
            else          m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) rom[i] = (32'(i * 4) << 20) | 32'h93;
        rom['h20 / 4] = JAL_16;
        rom['h10 / 4] = BEQ_M8;

        //  rst stl fls redir upd upc   tkn  pc     PC_out instr        pred
        add(0, 0, 0, 0,     0, 0,    0,   0,     0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   4,     0,     R(0),        0);
        add(1, 0, 0, 0,     0, 0,    0,   8,     4,     R(4),        0);
        add(1, 1, 0, 0,     0, 0,    0,   8,     4,     R(4),        0);
        add(1, 1, 0, 0,     0, 0,    0,   8,     4,     R(4),        0);
        add(1, 0, 0, 0,     0, 0,    0,   12,    8,     R(8),        0);
        add(1, 1, 1, 'h40,  0, 0,    0,   'h40,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h44,  'h40,  R('h40),     0);
        add(1, 0, 1, 'h20,  0, 0,    0,   'h20,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h30,  'h20,  JAL_16,      1);
        add(1, 0, 0, 0,     0, 0,    0,   'h34,  'h30,  R('h30),     0);
        add(1, 0, 1, 'h10,  0, 0,    0,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     1, 'h10, 1,   'h14,  'h10,  BEQ_M8,      0);
        add(1, 0, 1, 'h10,  0, 0,    0,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h08,  'h10,  BEQ_M8,      1);
        add(1, 0, 1, 'h10,  1, 'h10, 1,   'h10,  0,     NOP,         0);
        add(1, 0, 1, 'h10,  1, 'h10, 1,   'h10,  0,     NOP,         0);
        add(1, 0, 1, 'h10,  1, 'h10, 0,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h08,  'h10,  BEQ_M8,      1);
        add(1, 0, 1, 'h10,  1, 'h10, 0,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h14,  'h10,  BEQ_M8,      0);
        add(1, 0, 1, 'h10,  1, 'h10, 0,   'h10,  0,     NOP,         0);
        add(1, 0, 1, 'h10,  1, 'h10, 0,   'h10,  0,     NOP,         0);
        add(1, 0, 1, 'h10,  1, 'h10, 1,   'h10,  0,     NOP,         0);
        add(1, 0, 1, 'h10,  1, 'h10, 1,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h08,  'h10,  BEQ_M8,      1);
        add(0, 0, 1, 'h40,  1, 'h10, 1,   0,     0,     NOP,         0);
        add(1, 0, 1, 'h10,  0, 0,    0,   'h10,  0,     NOP,         0);
        add(1, 0, 0, 0,     0, 0,    0,   'h14,  'h10,  BEQ_M8,      0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].stl, tbl[i].fls, tbl[i].rdir,
                  tbl[i].upd, tbl[i].upc, tbl[i].tkn);
            tick();
            check($sformatf("row%0d_imem_addr", i), imem_addr, tbl[i].e_pc);
            check($sformatf("row%0d_PC_out", i), PC_out, tbl[i].e_pcout);
            check($sformatf("row%0d_instr", i), instruction_out, tbl[i].e_instr);
            check($sformatf("row%0d_predict", i), 32'(predict_out), 32'(tbl[i].e_pred));
        end

        // Randomized run: mixed ROM of addi / JAL / branch / JALR words.
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       rom[i] = ($urandom & 32'hFFF0_0000) | 32'h93;
                1:       rom[i] = ($urandom & ~32'h7F) | 32'h6F;
                2:       rom[i] = ($urandom & ~32'h7F) | 32'h63;
                default: rom[i] = ($urandom & ~32'h7F) | 32'h67;
            endcase
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        model_edge();
        tick();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  32'($urandom_range(0, 255)) * 4,
                  ($urandom_range(0, 2) == 0),
                  32'($urandom_range(0, 255)) * 4,
                  $urandom_range(0, 1) == 1);
            model_edge();
            tick();
            check($sformatf("rand%0d_imem_addr", c), imem_addr, m_pc);
            check($sformatf("rand%0d_PC_out", c), PC_out, m_pcout);
            check($sformatf("rand%0d_instr", c), instruction_out, m_instr);
            check($sformatf("rand%0d_predict", c), 32'(predict_out), 32'(m_pred));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
